// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: shared EX-stage bus widths, divider state encoding, ID->EX bus layout and ALU.
package ex_stage_pkg;
  localparam int DS_TO_ES_BUS_WD      = 154;
  localparam int ES_TO_MS_BUS_WD      = 107;
  localparam int ES_TO_DS_FORWARD_BUS = 39;
  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_e;
  typedef struct packed {
    logic [11:0] alu_op;
    logic        div_en;
    logic        div_signed;
    logic        div_mod;
    logic        res_from_mem;
    logic        gr_we;
    logic        mem_we;
    logic [4:0]  dest;
    logic        unsigned_ext_ld;
    logic [1:0]  st_size;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic [31:0] rkd_value;
    logic [31:0] pc;
  } ds_to_es_t;
  // one-hot alu_op, bit 0 first: add sub slt sltu and nor or xor sll srl sra lui
  function automatic logic [31:0] alu_calc(input logic [11:0] op, input logic [31:0] a, input logic [31:0] b);
    return op[0]  ? a + b :
           op[1]  ? a - b :
           op[2]  ? {31'b0, $signed(a) < $signed(b)} :
           op[3]  ? {31'b0, a < b} :
           op[4]  ? a & b :
           op[5]  ? ~(a | b) :
           op[6]  ? a | b :
           op[7]  ? a ^ b :
           op[8]  ? a << b[4:0] :
           op[9]  ? a >> b[4:0] :
           op[10] ? $unsigned($signed(a) >>> b[4:0]) :
           op[11] ? b : '0;
  endfunction
endpackage

// File: rtl/ex_stage_div_iter.sv
// div_iter: restoring radix-2 divider, one quotient bit per BUSY cycle, 32 BUSY cycles.
// Ports: clk, reset (sync, active-high); start/signed_op/dividend/divisor launch a divide from
// IDLE; flush aborts to IDLE; ack releases DONE; busy/done report state; quotient/remainder
// are sign-corrected and held stable while DONE.
module div_iter
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        flush,
  input  logic        ack,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);
  div_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d, quo_q, quo_d, dsr_q, dsr_d;
  logic        q_neg_q, q_neg_d, r_neg_q, r_neg_d, a_neg, b_neg;
  logic [32:0] rem_sh;
  logic [33:0] rem_sub;
  always_comb begin
    a_neg   = signed_op && dividend[31];
    b_neg   = signed_op && divisor[31];
    // quo_q doubles as the dividend shift register: its MSB feeds the partial remainder
    rem_sh  = {rem_q, quo_q[31]};
    rem_sub = {1'b0, rem_sh} - {2'b0, dsr_q};
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dsr_d   = dsr_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    if (reset) begin
      state_d = DIV_IDLE;
      cnt_d   = '0;
      rem_d   = '0;
      quo_d   = '0;
      dsr_d   = '0;
      q_neg_d = 1'b0;
      r_neg_d = 1'b0;
    end else if (flush) begin
      state_d = DIV_IDLE;
      cnt_d   = '0;
    end else if (state_q == DIV_IDLE && start) begin
      state_d = DIV_BUSY;
      cnt_d   = '0;
      rem_d   = '0;
      quo_d   = a_neg ? -dividend : dividend;
      dsr_d   = b_neg ? -divisor : divisor;
      q_neg_d = a_neg ^ b_neg;
      r_neg_d = a_neg;
    end else if (state_q == DIV_BUSY) begin
      // a borrow out of bit 33 means the trial subtraction failed: restore
      rem_d   = rem_sub[33] ? rem_sh[31:0] : rem_sub[31:0];
      quo_d   = {quo_q[30:0], ~rem_sub[33]};
      cnt_d   = cnt_q + 5'd1;
      state_d = (cnt_q == 5'd31) ? DIV_DONE : DIV_BUSY;
    end else if (state_q == DIV_DONE && ack) begin
      state_d = DIV_IDLE;
    end
    busy      = state_q == DIV_BUSY;
    done      = state_q == DIV_DONE;
    quotient  = q_neg_q ? -quo_q : quo_q;
    remainder = r_neg_q ? -rem_q : rem_q;
  end
  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
    rem_q   <= rem_d;
    quo_q   <= quo_d;
    dsr_q   <= dsr_d;
    q_neg_q <= q_neg_d;
    r_neg_q <= r_neg_d;
  end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: EX pipeline stage -- ALU, iterative divider, ID/MEM handshakes, forwarding, data SRAM request.
// Ports: clk, reset (sync, active-high); es_stall/es_flush from the hazard unit; ds_to_es_valid/bus
// and es_allowin toward ID; es_to_ms_valid/bus and ms_allowin toward MEM; es_to_ds_forward_bus
// {fwd_en, es_blocked, dest, es_result}; data_sram_en/addr request the data SRAM.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            es_stall,
  input  logic                            es_flush,
  input  logic                            ms_allowin,
  output logic                            es_allowin,
  input  logic                            ds_to_es_valid,
  input  logic [DS_TO_ES_BUS_WD-1:0]      ds_to_es_bus,
  output logic                            es_to_ms_valid,
  output logic [ES_TO_MS_BUS_WD-1:0]      es_to_ms_bus,
  output logic [ES_TO_DS_FORWARD_BUS-1:0] es_to_ds_forward_bus,
  output logic                            data_sram_en,
  output logic [31:0]                     data_sram_addr
);
  ds_to_es_t   bus_q, bus_d;
  logic        es_valid_q, es_valid_d, es_ready_go, es_blocked, fwd_en;
  logic        div_start, div_ack, div_busy, div_done;
  logic [31:0] alu_result, es_result, div_quo, div_rem;
  div_iter u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .signed_op (bus_q.div_signed),
    .dividend  (bus_q.alu_src1),
    .divisor   (bus_q.alu_src2),
    .flush     (es_flush),
    .ack       (div_ack),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );
  always_comb begin
    alu_result           = alu_calc(bus_q.alu_op, bus_q.alu_src1, bus_q.alu_src2);
    es_ready_go          = !bus_q.div_en || div_done;
    es_allowin           = (!es_valid_q || (es_ready_go && ms_allowin)) && !es_stall;
    es_to_ms_valid       = es_valid_q && es_ready_go;
    div_start            = es_valid_q && bus_q.div_en && !div_busy && !div_done;
    div_ack              = es_to_ms_valid && ms_allowin;
    es_result            = bus_q.div_en ? (bus_q.div_mod ? div_rem : div_quo) : alu_result;
    fwd_en               = es_valid_q && bus_q.gr_we && (bus_q.dest != 5'd0);
    es_blocked           = es_valid_q && (bus_q.res_from_mem || (bus_q.div_en && !div_done));
    es_to_ms_bus         = {bus_q.res_from_mem, bus_q.gr_we, bus_q.mem_we, bus_q.dest,
                            bus_q.unsigned_ext_ld, bus_q.st_size, es_result, bus_q.rkd_value, bus_q.pc};
    es_to_ds_forward_bus = {fwd_en, es_blocked, bus_q.dest, es_result};
    data_sram_en         = es_valid_q && (bus_q.res_from_mem || bus_q.mem_we) && ms_allowin && !es_flush;
    data_sram_addr       = alu_result;
    es_valid_d           = (reset || es_flush) ? 1'b0 : es_allowin ? ds_to_es_valid : es_valid_q;
    bus_d                = reset ? '0 : (ds_to_es_valid && es_allowin) ? ds_to_es_t'(ds_to_es_bus) : bus_q;
  end
  always_ff @(posedge clk) begin
    es_valid_q <= es_valid_d;
    bus_q      <= bus_d;
  end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: scoreboard bench for ex_stage with directed corner cases and randomized traffic.
module tb_ex_stage;
  logic         clk = 1'b0, reset = 1'b1, es_stall = 1'b0, es_flush = 1'b0, ms_allowin = 1'b1;
  logic         ds_to_es_valid = 1'b0;
  logic [153:0] ds_to_es_bus = '0;
  logic         es_allowin, es_to_ms_valid, data_sram_en;
  logic [106:0] es_to_ms_bus;
  logic [38:0]  fwd;
  logic [31:0]  data_sram_addr;

  ex_stage dut (
    .clk                  (clk),
    .reset                (reset),
    .es_stall             (es_stall),
    .es_flush             (es_flush),
    .ms_allowin           (ms_allowin),
    .es_allowin           (es_allowin),
    .ds_to_es_valid       (ds_to_es_valid),
    .ds_to_es_bus         (ds_to_es_bus),
    .es_to_ms_valid       (es_to_ms_valid),
    .es_to_ms_bus         (es_to_ms_bus),
    .es_to_ds_forward_bus (fwd),
    .data_sram_en         (data_sram_en),
    .data_sram_addr       (data_sram_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [106:0] bus;
    logic [31:0]  res;
    logic [31:0]  addr;
    logic         div;
    logic         mem;
    logic         rfm;
    logic [4:0]   dest;
    logic         fwd_en;
    int           acc;
  } ent_t;

  ent_t        q[$];
  ent_t        h;
  int          cyc = 0, checks = 0, fails = 0, age;
  bit          rdy, rand_en = 1'b0;
  logic [31:0] corner [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};
  localparam logic [11:0] OP_ADD = 12'h001;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [106:0] a, input logic [106:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [11:0] op, input logic [31:0] a, input logic [31:0] b);
    int     sh = int'(b[4:0]);
    longint sa = longint'($signed(a));
    for (int i = 0; i < 12; i++)
      if (op[i])
        case (i)
          0:  return a + b;
          1:  return a - b;
          2:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          3:  return (a < b) ? 32'd1 : 32'd0;
          4:  return a & b;
          5:  return ~(a | b);
          6:  return a | b;
          7:  return a ^ b;
          8:  return a << sh;
          9:  return a >> sh;
          10: return 32'(sa >>> sh);
          default: return b;
        endcase
    return 32'd0;
  endfunction

  function automatic logic [31:0] ref_div(input logic sg, input logic md, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ma, mb, qm, rm;
    logic        na, nb;
    na = sg && a[31];
    nb = sg && b[31];
    ma = na ? (64'h1_0000_0000 - {32'b0, a}) : {32'b0, a};
    mb = nb ? (64'h1_0000_0000 - {32'b0, b}) : {32'b0, b};
    qm = (mb == 0) ? 64'hFFFF_FFFF : ma / mb;
    rm = (mb == 0) ? ma : ma % mb;
    if (na ^ nb) qm = -qm;
    if (na) rm = -rm;
    return md ? rm[31:0] : qm[31:0];
  endfunction

  function automatic logic [153:0] mk(input logic [11:0] op, input logic dv, input logic sg, input logic md,
                                      input logic rfm, input logic gwe, input logic mwe, input logic [4:0] dest,
                                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] rkd, input logic [31:0] pc);
    return {op, dv, sg, md, rfm, gwe, mwe, dest, rkd[2:0], a, b, rkd, pc};
  endfunction

  // Offer one instruction until ES accepts it, then record what MEM must eventually receive.
  task automatic send(input logic [153:0] b, input logic [31:0] exp_res);
    bit   ok = 1'b0;
    int   t = 0;
    ent_t e;
    ds_to_es_valid = 1'b1;
    ds_to_es_bus   = b;
    while (!ok && t < 300) begin
      @(negedge clk);
      ok = es_allowin;
      @(posedge clk);
      #1;
      t++;
    end
    ds_to_es_valid = 1'b0;
    if (!ok) begin
      checks++;
      fails++;
      $display("FAIL accept: instruction not accepted within %0d cycles, expected acceptance", t);
    end else begin
      e.res    = exp_res;
      e.addr   = ref_alu(b[153:142], b[127:96], b[95:64]);
      e.div    = b[141];
      e.rfm    = b[138];
      e.mem    = b[138] | b[136];
      e.dest   = b[135:131];
      e.fwd_en = b[137] && (b[135:131] != 5'd0);
      e.bus    = {b[138], b[137], b[136], b[135:131], b[130], b[129:128], exp_res, b[63:32], b[31:0]};
      e.acc    = cyc;
      q.push_back(e);
    end
  endtask

  task automatic send_ref(input logic [153:0] b);
    send(b, b[141] ? ref_div(b[140], b[139], b[127:96], b[95:64]) : ref_alu(b[153:142], b[127:96], b[95:64]));
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    #1;
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d instructions still in ES, expected 0", q.size());
    end
  endtask

  // Monitor: ES holds at most one instruction, so the queue head is the ES content.
  always @(negedge clk) if (!reset) begin
    if (q.size() == 0) begin
      chk("empty_to_ms_valid", es_to_ms_valid, 0);
      chk("empty_allowin", es_allowin, !es_stall);
      chk("empty_sram_en", data_sram_en, 0);
      chk("empty_fwd_en", fwd[38], 0);
      chk("empty_blocked", fwd[37], 0);
    end else begin
      h   = q[0];
      age = cyc - h.acc;
      rdy = !h.div || age >= 33;
      chk("to_ms_valid", es_to_ms_valid, rdy);
      chk("allowin", es_allowin, rdy && ms_allowin && !es_stall);
      chk("fwd_en", fwd[38], h.fwd_en);
      chk("blocked", fwd[37], h.rfm || (h.div && !rdy));
      chk("fwd_dest", fwd[36:32], h.dest);
      chk("sram_en", data_sram_en, h.mem && ms_allowin && !es_flush);
      if (h.mem) chk("sram_addr", data_sram_addr, h.addr);
      if (rdy) begin
        chk("to_ms_bus", es_to_ms_bus, h.bus);
        chk("fwd_result", fwd[31:0], h.res);
      end
      if (es_flush) void'(q.pop_front());
      else if (rdy && ms_allowin) void'(q.pop_front());
    end
  end

  // Random backpressure; stalls only while ES is empty or a divide is mid-iteration.
  always @(posedge clk) if (rand_en) begin
    #2;
    ms_allowin = ($urandom % 4) != 0;
    es_stall   = (q.size() == 0 || (q[0].div && (cyc - q[0].acc) >= 2 && (cyc - q[0].acc) <= 25)) && ($urandom % 3 == 0);
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    int          kind;
    logic        rfm;
    step(3);
    reset = 1'b0;
    step(2);
    send(mk(OP_ADD, 0, 0, 0, 0, 1, 0, 5'd4, 32'd5, 32'd7, 32'h11, 32'h1c00_0000), 32'd12);
    drain();
    send(mk(12'h0, 1, 1, 0, 0, 1, 0, 5'd5, 32'hFFFF_FFF9, 32'd2, 32'h0, 32'h1c00_0004), 32'hFFFF_FFFD);
    send(mk(12'h0, 1, 1, 1, 0, 1, 0, 5'd6, 32'hFFFF_FFF9, 32'd2, 32'h0, 32'h1c00_0008), 32'hFFFF_FFFF);
    send(mk(12'h0, 1, 0, 0, 0, 1, 0, 5'd7, 32'd100, 32'd0, 32'h0, 32'h1c00_000c), 32'hFFFF_FFFF);
    send(mk(12'h0, 1, 0, 1, 0, 1, 0, 5'd8, 32'd100, 32'd0, 32'h0, 32'h1c00_0010), 32'd100);
    send(mk(12'h0, 1, 1, 0, 0, 1, 0, 5'd9, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h1c00_0014), 32'h8000_0000);
    send(mk(12'h0, 1, 1, 1, 0, 1, 0, 5'd10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h1c00_0018), 32'h0);
    drain();
    send(mk(12'h0, 1, 0, 0, 0, 1, 0, 5'd11, 32'd7, 32'd3, 32'h0, 32'h1c00_001c), 32'd2);
    step(10);
    es_flush = 1'b1;
    step(1);
    es_flush = 1'b0;
    send(mk(OP_ADD, 0, 0, 0, 0, 1, 0, 5'd12, 32'd1, 32'd2, 32'h0, 32'h1c00_0020), 32'd3);
    send(mk(12'h0, 1, 0, 1, 0, 1, 0, 5'd13, 32'd47, 32'd5, 32'h0, 32'h1c00_0024), 32'd2);
    drain();
    send(mk(12'h0, 1, 0, 0, 0, 1, 0, 5'd14, 32'd1000, 32'd7, 32'h0, 32'h1c00_0028), 32'd142);
    step(30);
    ms_allowin = 1'b0;
    step(10);
    ms_allowin = 1'b1;
    drain();
    ms_allowin = 1'b0;
    send(mk(OP_ADD, 0, 0, 0, 1, 1, 0, 5'd15, 32'h1000, 32'd8, 32'h0, 32'h1c00_002c), 32'h1008);
    step(3);
    ms_allowin = 1'b1;
    drain();
    send(mk(OP_ADD, 0, 0, 0, 0, 0, 1, 5'd0, 32'h2000, 32'h10, 32'hDEAD_BEEF, 32'h1c00_0030), 32'h2010);
    drain();
    rand_en = 1'b1;
    for (int n = 0; n < 80; n++) begin
      kind = int'($urandom % 10);
      a = $urandom;
      b = ($urandom % 4 == 0) ? corner[$urandom % 6] : $urandom;
      if ($urandom % 5 == 0) a = corner[$urandom % 6];
      rfm = 1'($urandom % 2);
      if (kind < 6)
        send_ref(mk(12'(1) << ($urandom % 12), 0, 0, 0, 0, 1'($urandom), 0, 5'($urandom), a, b, $urandom, $urandom));
      else if (kind < 8)
        send_ref(mk(12'h0, 1, 1'($urandom), 1'($urandom), 0, 1, 0, 5'($urandom), a, b, $urandom, $urandom));
      else
        send_ref(mk(OP_ADD, 0, 0, 0, rfm, rfm, !rfm, 5'($urandom), a, 32'($urandom % 2048), $urandom, $urandom));
      step(int'($urandom % 3));
    end
    rand_en = 1'b0;
    @(posedge clk);
    #3;
    es_stall   = 1'b0;
    ms_allowin = 1'b1;
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 Parameters: none; all bus widths SHALL come from shared macros DS_TO_ES_BUS_WD=154, ES_TO_MS_BUS_WD=107, ES_TO_DS_FORWARD_BUS=39.
REQ-002 clk  in  1  clock; all state SHALL update on posedge.
REQ-003 reset  in  1  reset, synchronous, active-high.
REQ-004 es_stall  in  1  hazard-unit hold; forces es_allowin low.
REQ-005 es_flush  in  1  hazard-unit kill of the ES instruction.
REQ-006 ms_allowin  in  1  downstream MEM stage accepts this cycle.
REQ-007 es_allowin  out  1  ES accepts from ID this cycle.
REQ-008 ds_to_es_valid  in  1  ID offers an instruction.
REQ-009 ds_to_es_bus  in  154  {alu_op[12], div_en, div_signed, div_mod, res_from_mem, gr_we, mem_we, dest[5], unsigned_ext_ld, st_size[2], alu_src1[32], alu_src2[32], rkd_value[32], pc[32]}, MSB first.
REQ-010 es_to_ms_valid  out  1  ES offers an instruction to MEM.
REQ-011 es_to_ms_bus  out  107  {res_from_mem, gr_we, mem_we, dest[5], unsigned_ext_ld, st_size[2], es_result[32], rkd_value[32], pc[32]}, MSB first.
REQ-012 es_to_ds_forward_bus  out  39  {fwd_en, es_blocked, dest[5], es_result[32]}.
REQ-013 data_sram_en  out  1  data SRAM access request.
REQ-014 data_sram_addr  out  32  data SRAM byte address.

Function
REQ-015 Pipeline register SHALL capture ds_to_es_bus when ds_to_es_valid && es_allowin; es_valid <= ds_to_es_valid when es_allowin.
REQ-016 es_allowin SHALL equal (!es_valid || (es_ready_go && ms_allowin)) && !es_stall.
REQ-017 es_to_ms_valid SHALL equal es_valid && es_ready_go.
REQ-018 es_result SHALL be the divider result when div_en, else the output of the existing alu module (alu_op, alu_src1, alu_src2).
REQ-019 Non-divide instructions: es_ready_go=1, zero added latency.
REQ-020 Divider FSM states IDLE, BUSY, DONE; IDLE->BUSY when es_valid && div_en && !es_flush; counter loads 0.
REQ-021 BUSY: restoring radix-2, one quotient bit per cycle; BUSY->DONE after exactly 32 BUSY cycles (counter 31 -> DONE).
REQ-022 DONE: result held stable; es_ready_go=1; DONE->IDLE when es_to_ms_valid && ms_allowin.
REQ-023 Divide latency: instruction valid in ES in cycle N leaves ES no earlier than the end of cycle N+33.
REQ-024 div_mod=0 selects quotient, div_mod=1 remainder; div_signed operates on magnitudes, quotient negated iff operand signs differ, remainder takes dividend sign.
REQ-025 Divide by zero: quotient 0xFFFFFFFF (unsigned) or as produced by magnitude algorithm with sign fix (signed); remainder = dividend.
REQ-026 Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
REQ-027 es_flush or reset in any FSM state SHALL return FSM to IDLE next cycle and clear es_valid; no partial result escapes.
REQ-028 es_stall with divide in BUSY SHALL NOT pause iteration.
REQ-029 fwd_en = es_valid && gr_we && dest!=0; es_blocked = es_valid && (res_from_mem || (div_en && FSM!=DONE)).
REQ-030 data_sram_en = es_valid && (res_from_mem || mem_we) && ms_allowin && !es_flush; data_sram_addr = alu result.

Reset
REQ-031 On reset: es_valid=0, pipeline register=0, FSM=IDLE, counter=0; hence es_to_ms_valid=0, data_sram_en=0, fwd_en=0, es_blocked=0, es_allowin=1 (if !es_stall).

Structure
REQ-032 Bus-width macros and FSM state encodings SHALL live in the shared myCPU.vh header.
REQ-033 Divider SHALL be one sub-module, div_iter (start, signed, dividend, divisor, flush -> busy, done, quotient, remainder).

Verification
REQ-034 add.w 5+7, ms_allowin=1 -> es_to_ms_valid next cycle, es_result=12, data_sram_en=0.
REQ-035 div.w 0xFFFFFFF9 / 2 -> es_ready_go low 33 cycles, then quotient 0xFFFFFFFD; mod.w -> 0xFFFFFFFF.
REQ-036 div.wu 100/0 -> quotient 0xFFFFFFFF; mod.wu -> 100; signed 0x80000000/-1 -> 0x80000000, remainder 0.
REQ-037 es_flush at BUSY cycle 10 -> FSM IDLE next cycle, es_valid=0, following add.w completes in 1 cycle with correct result.
REQ-038 DONE with ms_allowin=0 for 5 cycles -> result and es_to_ms_bus stable, es_allowin=0; released when ms_allowin=1.
REQ-039 ld.w in ES, ms_allowin=1 -> data_sram_en=1, addr=alu result, es_blocked=1; with ms_allowin=0 -> data_sram_en=0.
